// File: rtl/trap_ctrl_pkg.sv
// Shared machine-mode CSR definitions for the trap sequencer.
//   - interrupt cause codes (MEI, MSI, MTI)
//   - mtvec mode encodings
//   - sequencer state encoding
//   - trap vector target helper
package trap_ctrl_pkg;

  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_COMMIT = 2'd2,
    ST_RET    = 2'd3
  } state_e;

  // Only interrupts are vectored; modes 10/11 fall back to direct.
  // The add wraps modulo 2^32 by construction of the 32-bit result.
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec,
                                              input logic        is_irq,
                                              input logic [3:0]  cause);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (is_irq && mtvec[1:0] == MTVEC_VECTORED)
      trap_target = base + {26'd0, cause, 2'b00};
    else
      trap_target = base;
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchronizer for an asynchronous level input.
// Ports:
//   clk  - destination clock
//   rst  - asynchronous active-high reset, clears every stage to 0
//   d    - asynchronous level input
//   q    - synchronized level, SYNC_STAGES cycles behind d
module trap_ctrl_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // NOTE: sequential state uses non-blocking assignments so every flop in
  // the chain samples the value its neighbour held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer between pipeline and CSR unit.
// Arbitrates exceptions, mret and the three machine interrupts, runs the
// flush/redirect handshake and emits one-cycle CSR write strobes.
// Ports:
//   clk_i, rst_i                 - clock, async active-high reset
//   irq_ext_i                    - external irq level (asynchronous)
//   irq_timer_i, irq_soft_i      - timer / software irq levels (synchronous)
//   mstatus_mie_i, mstatus_mpie_i, mie_i, mtvec_i, mepc_i - CSR state
//   pc_i                         - oldest unexecuted PC (interrupt EPC)
//   exc_valid_i, exc_cause_i, exc_pc_i - synchronous exception pulse
//   mret_i                       - mret pulse
//   flush_ack_i                  - pipeline drained
//   trap_req_o                   - flush request (held in FLUSH)
//   jump_o, jump_target_o        - redirect strobe and address
//   mepc_we_o/mepc_o, mcause_we_o/mcause_o, mstatus_we_o/mstatus_mie_o/
//   mstatus_mpie_o               - CSR write strobes and values
//   mip_o                        - live pending bits {meip, mtip, msip}
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        irq_ext_i,
  input  logic        irq_timer_i,
  input  logic        irq_soft_i,
  input  logic        mstatus_mie_i,
  input  logic        mstatus_mpie_i,
  input  logic [2:0]  mie_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] pc_i,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic        flush_ack_i,
  output logic        trap_req_o,
  output logic        jump_o,
  output logic [31:0] jump_target_o,
  output logic        mepc_we_o,
  output logic [31:0] mepc_o,
  output logic        mcause_we_o,
  output logic [31:0] mcause_o,
  output logic        mstatus_we_o,
  output logic        mstatus_mie_o,
  output logic        mstatus_mpie_o,
  output logic [2:0]  mip_o
);

  state_e      state_q, state_d;
  logic        is_irq_q, is_irq_d;
  logic [3:0]  cause_q, cause_d;
  logic [31:0] epc_q, epc_d;
  logic        capture;
  logic        ext_sync;
  logic [2:0]  irq_hit;
  logic        irq_take;

  trap_ctrl_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ext_sync (
    .clk (clk_i),
    .rst (rst_i),
    .d   (irq_ext_i),
    .q   (ext_sync)
  );

  assign mip_o    = {ext_sync, irq_timer_i, irq_soft_i};
  assign irq_hit  = mip_o & mie_i;
  assign irq_take = mstatus_mie_i && (irq_hit != 3'b000);

  // Strobes decode directly from the state register, so they are one clean
  // cycle wide and drop the instant reset clears the state.
  // NOTE: every signal driven here gets a default first, otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d        = state_q;
    capture        = 1'b0;
    is_irq_d       = 1'b0;
    cause_d        = 4'd0;
    epc_d          = 32'd0;
    trap_req_o     = 1'b0;
    jump_o         = 1'b0;
    jump_target_o  = 32'd0;
    mepc_we_o      = 1'b0;
    mepc_o         = 32'd0;
    mcause_we_o    = 1'b0;
    mcause_o       = 32'd0;
    mstatus_we_o   = 1'b0;
    mstatus_mie_o  = 1'b0;
    mstatus_mpie_o = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (exc_valid_i) begin
          capture = 1'b1;
          cause_d = exc_cause_i;
          epc_d   = exc_pc_i;
          state_d = ST_FLUSH;
        end else if (mret_i) begin
          state_d = ST_RET;
        end else if (irq_take) begin
          capture  = 1'b1;
          is_irq_d = 1'b1;
          epc_d    = pc_i;
          // Fixed priority MEI > MSI > MTI.
          if (irq_hit[2])      cause_d = CAUSE_MEI;
          else if (irq_hit[0]) cause_d = CAUSE_MSI;
          else                 cause_d = CAUSE_MTI;
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        trap_req_o = 1'b1;
        if (flush_ack_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        jump_o         = 1'b1;
        jump_target_o  = trap_target(mtvec_i, is_irq_q, cause_q);
        mepc_we_o      = 1'b1;
        mepc_o         = epc_q & 32'hFFFF_FFFE;
        mcause_we_o    = 1'b1;
        mcause_o       = {is_irq_q, 27'd0, cause_q};
        mstatus_we_o   = 1'b1;
        mstatus_mie_o  = 1'b0;
        mstatus_mpie_o = mstatus_mie_i;
        state_d        = ST_IDLE;
      end
      ST_RET: begin
        jump_o         = 1'b1;
        jump_target_o  = mepc_i & 32'hFFFF_FFFE;
        mstatus_we_o   = 1'b1;
        mstatus_mie_o  = mstatus_mpie_i;
        mstatus_mpie_o = 1'b1;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the captured trap context is reset along with the state so the
  // CSR values are defined from the very first cycle, not just after a trap.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      is_irq_q <= 1'b0;
      cause_q  <= 4'd0;
      epc_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        is_irq_q <= is_irq_d;
        cause_q  <= cause_d;
        epc_q    <= epc_d;
      end
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed self-checking bench for trap_ctrl.
module tb_trap_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        irq_ext_i, irq_timer_i, irq_soft_i;
  logic        mstatus_mie_i, mstatus_mpie_i;
  logic [2:0]  mie_i;
  logic [31:0] mtvec_i, mepc_i, pc_i;
  logic        exc_valid_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        mret_i, flush_ack_i;
  logic        trap_req_o, jump_o;
  logic [31:0] jump_target_o;
  logic        mepc_we_o;
  logic [31:0] mepc_o;
  logic        mcause_we_o;
  logic [31:0] mcause_o;
  logic        mstatus_we_o, mstatus_mie_o, mstatus_mpie_o;
  logic [2:0]  mip_o;

  int checks = 0;
  int failures = 0;

  trap_ctrl #(.SYNC_STAGES(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i), .irq_soft_i(irq_soft_i),
    .mstatus_mie_i(mstatus_mie_i), .mstatus_mpie_i(mstatus_mpie_i),
    .mie_i(mie_i), .mtvec_i(mtvec_i), .mepc_i(mepc_i), .pc_i(pc_i),
    .exc_valid_i(exc_valid_i), .exc_cause_i(exc_cause_i), .exc_pc_i(exc_pc_i),
    .mret_i(mret_i), .flush_ack_i(flush_ack_i),
    .trap_req_o(trap_req_o), .jump_o(jump_o), .jump_target_o(jump_target_o),
    .mepc_we_o(mepc_we_o), .mepc_o(mepc_o),
    .mcause_we_o(mcause_we_o), .mcause_o(mcause_o),
    .mstatus_we_o(mstatus_we_o), .mstatus_mie_o(mstatus_mie_o),
    .mstatus_mpie_o(mstatus_mpie_o), .mip_o(mip_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs set afterwards are sampled at
  // the following edge, and outputs read here are settled.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_commit(input string tag, input logic [31:0] tgt,
                              input logic [31:0] epc, input logic [31:0] cause,
                              input logic mpie);
    check({tag, "_trap_req"}, {31'd0, trap_req_o}, 32'd0);
    check({tag, "_jump"}, {31'd0, jump_o}, 32'd1);
    check({tag, "_wes"}, {29'd0, mepc_we_o, mcause_we_o, mstatus_we_o}, 32'd7);
    check({tag, "_target"}, jump_target_o, tgt);
    check({tag, "_mepc"}, mepc_o, epc);
    check({tag, "_mcause"}, mcause_o, cause);
    check({tag, "_mie_o"}, {31'd0, mstatus_mie_o}, 32'd0);
    check({tag, "_mpie_o"}, {31'd0, mstatus_mpie_o}, {31'd0, mpie});
  endtask

  initial begin : stim
    int bad;
    rst_i = 1'b1;
    irq_ext_i = 0; irq_timer_i = 0; irq_soft_i = 0;
    mstatus_mie_i = 0; mstatus_mpie_i = 0; mie_i = 3'b000;
    mtvec_i = 32'h2000_0001; mepc_i = 32'h0; pc_i = 32'h0;
    exc_valid_i = 0; exc_cause_i = 4'd0; exc_pc_i = 32'h0;
    mret_i = 0; flush_ack_i = 0;

    #12;
    check("rst_trap_req", {31'd0, trap_req_o}, 32'd0);
    check("rst_strobes", {28'd0, jump_o, mepc_we_o, mcause_we_o, mstatus_we_o}, 32'd0);
    check("rst_mcause", mcause_o, 32'd0);
    check("rst_mip", {29'd0, mip_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();

    // Exception, direct target (mtvec vectored but exceptions never vector).
    mstatus_mie_i = 1; exc_valid_i = 1; exc_cause_i = 4'd2; exc_pc_i = 32'h100;
    tick();
    exc_valid_i = 0;
    check("exc_trap_req", {31'd0, trap_req_o}, 32'd1);
    check("exc_no_jump", {31'd0, jump_o}, 32'd0);
    tick();
    check("exc_trap_hold", {31'd0, trap_req_o}, 32'd1);
    flush_ack_i = 1;
    tick();
    check_commit("exc", 32'h2000_0000, 32'h100, 32'h0000_0002, 1'b1);
    flush_ack_i = 0;
    tick();
    check("exc_strobe_1cyc", {28'd0, jump_o, mepc_we_o, mcause_we_o, mstatus_we_o}, 32'd0);

    // Vectored timer interrupt.
    mie_i = 3'b010; irq_timer_i = 1; pc_i = 32'h340;
    tick();
    check("tmr_trap_req", {31'd0, trap_req_o}, 32'd1);
    flush_ack_i = 1;
    tick();
    check_commit("tmr", 32'h2000_001C, 32'h340, 32'h8000_0007, 1'b1);
    flush_ack_i = 0; mstatus_mie_i = 0;
    // Still pending, but globally masked now: must not retake.
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (trap_req_o || jump_o) bad++;
    end
    check("tmr_no_rearm", bad, 0);

    // Masking: all sources pending with mie=0; ext needs two sync cycles.
    mie_i = 3'b111; irq_soft_i = 1; irq_ext_i = 1;
    tick();
    check("mask_mip_1cyc", {29'd0, mip_o}, 32'b011);
    tick();
    check("mask_mip_2cyc", {29'd0, mip_o}, 32'b111);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (trap_req_o) bad++;
    end
    check("mask_no_trap", bad, 0);

    // Priority: exception beats three pending interrupts.
    mstatus_mie_i = 1; exc_valid_i = 1; exc_cause_i = 4'd11;
    exc_pc_i = 32'h200; pc_i = 32'h333;
    tick();
    exc_valid_i = 0; flush_ack_i = 1;   // ack on first FLUSH cycle
    check("pri_trap_req", {31'd0, trap_req_o}, 32'd1);
    tick();
    check_commit("pri_exc", 32'h2000_0000, 32'h200, 32'h0000_000B, 1'b1);
    flush_ack_i = 0; mstatus_mie_i = 0;
    tick();
    tick();
    check("pri_masked", {31'd0, trap_req_o}, 32'd0);
    mstatus_mie_i = 1;   // software re-enables: MEI wins, EPC bit 0 cleared
    tick();
    check("pri_irq_trap_req", {31'd0, trap_req_o}, 32'd1);
    flush_ack_i = 1;
    tick();
    check_commit("pri_mei", 32'h2000_002C, 32'h332, 32'h8000_000B, 1'b1);
    flush_ack_i = 0; mstatus_mie_i = 0; irq_ext_i = 0; irq_timer_i = 0;

    // Mode 10 is direct; soft interrupt alone gives cause 3.
    tick(); tick(); tick();
    mtvec_i = 32'h3000_0006; pc_i = 32'h500; mstatus_mie_i = 1;
    tick();
    flush_ack_i = 1;
    tick();
    check_commit("msi_mode2", 32'h3000_0004, 32'h500, 32'h8000_0003, 1'b1);
    flush_ack_i = 0; mstatus_mie_i = 0; irq_soft_i = 0; mie_i = 3'b000;
    tick();

    // mret.
    mepc_i = 32'h105; mstatus_mpie_i = 1; mret_i = 1;
    tick();
    mret_i = 0;
    check("ret_jump", {31'd0, jump_o}, 32'd1);
    check("ret_target", jump_target_o, 32'h104);
    check("ret_mstatus", {29'd0, mstatus_we_o, mstatus_mie_o, mstatus_mpie_o}, 32'b111);
    check("ret_no_csr_we", {30'd0, mepc_we_o, mcause_we_o}, 32'd0);
    check("ret_trap_req", {31'd0, trap_req_o}, 32'd0);
    tick();
    check("ret_strobe_1cyc", {31'd0, jump_o}, 32'd0);

    // Reset while in FLUSH, then a late ack.
    exc_valid_i = 1; exc_cause_i = 4'd5; exc_pc_i = 32'h700;
    tick();
    exc_valid_i = 0;
    check("rstf_trap_req", {31'd0, trap_req_o}, 32'd1);
    #2 rst_i = 1;
    #1;
    check("rstf_async_drop", {31'd0, trap_req_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 0;
    flush_ack_i = 1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (trap_req_o || jump_o || mepc_we_o || mcause_we_o || mstatus_we_o) bad++;
    end
    check("rstf_no_commit", bad, 0);
    flush_ack_i = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Machine-mode trap sequencer between the pipeline and the CSR unit. It arbitrates synchronous exceptions, `mret`, and the three machine interrupts (external, software, timer). It drives a flush/redirect handshake with the pipeline and emits the one-cycle write strobes that update `mepc`, `mcause` and `mstatus` in the CSR unit. It also supplies the live pending bits that the CSR unit returns for `mip` reads.

## Interface
- Reset is asynchronous and active-high. The block has a single clock.
- `SYNC_STAGES`, default 2: number of synchronizer flops on `irq_ext_i`. Legal range is ≥2.
- `clk_i` input 1: clock.
- `rst_i` input 1: asynchronous active-high reset.
- `irq_ext_i` input 1: external interrupt level. Asynchronous to `clk_i`.
- `irq_timer_i` input 1: timer interrupt level. Synchronous to `clk_i`.
- `irq_soft_i` input 1: software interrupt level. Synchronous to `clk_i`.
- `mstatus_mie_i` input 1: global interrupt enable, from the CSR unit.
- `mstatus_mpie_i` input 1: previous interrupt enable, from the CSR unit.
- `mie_i` input 3: enables {meie, mtie, msie}.
- `mtvec_i` input 32: trap vector register.
- `mepc_i` input 32: current `mepc` value, used as the `mret` target.
- `pc_i` input 32: PC of the oldest instruction not yet executed. This becomes the interrupt EPC.
- `exc_valid_i` input 1: synchronous exception, one-cycle pulse.
- `exc_cause_i` input 4: exception code.
- `exc_pc_i` input 32: PC of the faulting instruction.
- `mret_i` input 1: `mret` executing, one-cycle pulse.
- `flush_ack_i` input 1: pipeline is drained and ready for redirect.
- `trap_req_o` output 1: request pipeline flush.
- `jump_o` output 1: redirect strobe, one cycle.
- `jump_target_o` output 32: redirect address.
- `mepc_we_o` output 1: write strobe for `mepc`.
- `mepc_o` output 32: value for `mepc`.
- `mcause_we_o` output 1: write strobe for `mcause`.
- `mcause_o` output 32: value for `mcause`.
- `mstatus_we_o` output 1: write strobe for `mstatus`.
- `mstatus_mie_o` output 1: new `mie` value.
- `mstatus_mpie_o` output 1: new `mpie` value.
- `mip_o` output 3: pending bits {meip, mtip, msip}.

## Operation
- **States:**
  - IDLE: events are evaluated here.
  - FLUSH: `trap_req_o`=1.
  - COMMIT: one cycle, trap entry.
  - RET: one cycle, `mret`.
- **Pending bits.**
  - `mip_o` = {synchronized ext, `irq_timer_i`, `irq_soft_i`}.
  - These are levels only. No latching or clearing happens in this block.
- **Interrupt taken** when `mstatus_mie_i` is 1 and (`mip_o` & `mie_i`) ≠ 0.
- **IDLE arbitration order:**
  1. `exc_valid_i`
  2. `mret_i`
  3. MEI (cause 11)
  4. MSI (cause 3)
  5. MTI (cause 7)
- **Exception or interrupt in IDLE:**
  - The block captures `is_irq`, a 4-bit cause, and the EPC: `exc_pc_i` for an exception, `pc_i` for an interrupt.
  - It then moves to FLUSH.
- **`mret` in IDLE:** moves to RET.
- **FLUSH:**
  - Holds `trap_req_o`=1 until `flush_ack_i` is sampled at 1, then moves to COMMIT.
  - `exc_valid_i`, `mret_i` and interrupt changes are ignored while in FLUSH.
- **COMMIT** pulses `jump_o`, `mepc_we_o`, `mcause_we_o` and `mstatus_we_o`, with these values:
  - `mepc_o` = {epc[31:1], 0}.
  - `mcause_o` = {is_irq, 27'd0, cause}.
  - `mstatus_mie_o` = 0.
  - `mstatus_mpie_o` = `mstatus_mie_i`.
  - `jump_target_o` = base + 4·cause when `mtvec_i`[1:0]=01 and is_irq. Otherwise it is base.
  - base = {`mtvec_i`[31:2], 2'b00}. Modes 10 and 11 are treated as direct.
  - COMMIT returns to IDLE.
- **RET** pulses `jump_o` and `mstatus_we_o`, with these values, then returns to IDLE:
  - `jump_target_o` = {`mepc_i`[31:1], 0}.
  - `mstatus_mie_o` = `mstatus_mpie_i`.
  - `mstatus_mpie_o` = 1.
- **Width rule:** target addition is modulo 2^32, and cause is zero-extended.

## Timing
- **Reset values:** state is IDLE, every output and every synchronizer flop is 0, and the captured cause and EPC registers are 0.
- **Reset mid-operation:** in any state, reset returns the block to IDLE immediately (asynchronously) with no strobes. An ack arriving after reset is ignored.
- **Exception latency:** event sampled at edge N gives `trap_req_o`=1 from N+1. Ack sampled at edge M gives COMMIT strobes during cycle M+1, and `trap_req_o`=0 in that cycle.
- **Same-cycle ack:** if `flush_ack_i` is already 1 on the first FLUSH cycle, COMMIT follows on the next cycle.
- **`mret` latency:** `mret_i` at edge N gives RET strobes in cycle N+1.
- **External interrupt latency:** adds `SYNC_STAGES` cycles before it is visible in `mip_o` and in arbitration.
- **Strobe width:** all strobes are registered and exactly one cycle wide. COMMIT and RET are never back-to-back; IDLE always lies between them.
- **Re-arm:** an interrupt still pending after COMMIT is not retaken, because the CSR unit now reports `mstatus_mie_i`=0.
- **Inputs during COMMIT/RET** are ignored.

## Structure
- Shared CSR definitions header holds:
  - cause codes: MEI=11, MSI=3, MTI=7;
  - `mtvec` mode encodings: DIRECT=0, VECTORED=1;
  - state encodings.
- Sub-module `irq_sync`: parameterized `SYNC_STAGES` flop chain with async reset to 0, used for `irq_ext_i`.

## Test plan
- **Exception, direct target:** `exc_valid_i`=1, cause=2, `exc_pc_i`=0x100, `mtvec_i`=0x2000_0001, `mstatus_mie_i`=1.
  - Expect `trap_req_o` on the next cycle.
  - After ack, COMMIT gives target 0x2000_0000, `mepc_o` 0x100, `mcause_o` 0x0000_0002, mie=0, mpie=1.
- **Vectored timer interrupt:** `mtvec_i`=0x2000_0001, `mie_i`=010, `irq_timer_i`=1, `pc_i`=0x340.
  - Expect target 0x2000_001C, `mcause_o` 0x8000_0007, `mepc_o` 0x340.
- **Priority:** all three interrupts pending and enabled, with `exc_valid_i` in the same cycle and cause=11 (ecall).
  - First trap is the exception: `mcause_o` 0x0000_000B.
  - After software sets mie=1, the next trap gives `mcause_o` 0x8000_000B and target base+0x2C.
- **Masking:** all sources pending, `mstatus_mie_i`=0.
  - Expect no `trap_req_o` for 20 cycles.
  - Expect `mip_o`=111 two cycles after `irq_ext_i` rises.
- **`mret`:** `mepc_i`=0x105, `mstatus_mpie_i`=1, `mret_i` pulse.
  - Next cycle expect `jump_o`=1, target 0x104, `mstatus_mie_o`=1, `mstatus_mpie_o`=1.
- **Reset in FLUSH:** assert `rst_i` while in FLUSH, then ack after reset.
  - Expect `trap_req_o` to fall without a clock edge.
  - Expect no COMMIT strobes afterwards.
